// File: rtl/filtro_medidas.sv
// filtro_medidas: moving-average filter for DHT11 temperature/humidity with consecutive-error detection
module filtro_medidas #(
  parameter int N_LOG2 = 2,
  parameter int MAX_ERROS = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              limpa,
  input  logic              pronto_medida,
  input  logic              erro_medida,
  input  logic [15:0]       temperatura,
  input  logic [15:0]       umidade,
  output logic [15:0]       temperatura_media,
  output logic [15:0]       umidade_media,
  output logic              media_pronta,
  output logic              media_valida,
  output logic              erro_sensor,
  output logic [N_LOG2:0]   db_num_amostras,
  output logic [2:0]        db_estado
);
  localparam int W = 12 + N_LOG2;
  localparam int D = 1 << N_LOG2;
  localparam int CW = $clog2(MAX_ERROS + 1);
  localparam logic [2:0] OCIOSO = 3'd0, ATUALIZA = 3'd1, CONVERTE = 3'd2, PUBLICA = 3'd3;
  localparam logic [N_LOG2:0] NUM_MAX = {1'b1, {N_LOG2{1'b0}}};
  localparam logic [CW-1:0] ERR_MAX = CW'(MAX_ERROS);
  logic [2:0] estado;
  logic [11:0] t_lat, u_lat, q_t, q_u;
  logic [11:0] buf_t [D];
  logic [11:0] buf_u [D];
  logic [W-1:0] soma_t, soma_u;
  logic [N_LOG2-1:0] ptr;
  logic [CW-1:0] erros;
  function automatic logic [11:0] decimos(input logic [15:0] v);
    return 12'(v[15:8]) * 12'd10 + ((v[7:0] > 8'd9) ? 12'd9 : 12'(v[7:0]));
  endfunction
  assign q_t = soma_t[W-1:N_LOG2];
  assign q_u = soma_u[W-1:N_LOG2];
  assign media_pronta = estado == PUBLICA;
  assign db_estado = estado;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      estado <= OCIOSO;
      t_lat <= '0;
      u_lat <= '0;
      soma_t <= '0;
      soma_u <= '0;
      ptr <= '0;
      erros <= '0;
      erro_sensor <= 1'b0;
      media_valida <= 1'b0;
      db_num_amostras <= '0;
      temperatura_media <= '0;
      umidade_media <= '0;
      for (int i = 0; i < D; i++) begin
        buf_t[i] <= '0;
        buf_u[i] <= '0;
      end
    end else if (limpa) begin
      estado <= OCIOSO;
      t_lat <= '0;
      u_lat <= '0;
      soma_t <= '0;
      soma_u <= '0;
      ptr <= '0;
      erros <= '0;
      erro_sensor <= 1'b0;
      media_valida <= 1'b0;
      db_num_amostras <= '0;
      temperatura_media <= '0;
      umidade_media <= '0;
      for (int i = 0; i < D; i++) begin
        buf_t[i] <= '0;
        buf_u[i] <= '0;
      end
    end else begin
      case (estado)
        OCIOSO:
          if (erro_medida) begin
            if (erros != ERR_MAX) erros <= erros + 1'b1;
            erro_sensor <= erro_sensor | (erros == ERR_MAX - 1'b1);
          end else if (pronto_medida) begin
            t_lat <= decimos(temperatura);
            u_lat <= decimos(umidade);
            estado <= ATUALIZA;
          end
        ATUALIZA: begin
          // the first sample preloads the whole window so the average is meaningful immediately
          if (!media_valida) begin
            for (int i = 0; i < D; i++) begin
              buf_t[i] <= t_lat;
              buf_u[i] <= u_lat;
            end
            soma_t <= W'(t_lat) << N_LOG2;
            soma_u <= W'(u_lat) << N_LOG2;
            ptr <= '0;
          end else begin
            soma_t <= soma_t - W'(buf_t[ptr]) + W'(t_lat);
            soma_u <= soma_u - W'(buf_u[ptr]) + W'(u_lat);
            buf_t[ptr] <= t_lat;
            buf_u[ptr] <= u_lat;
            ptr <= ptr + 1'b1;
          end
          if (db_num_amostras != NUM_MAX) db_num_amostras <= db_num_amostras + 1'b1;
          media_valida <= 1'b1;
          erros <= '0;
          erro_sensor <= 1'b0;
          estado <= CONVERTE;
        end
        CONVERTE: begin
          temperatura_media <= {8'(q_t / 12'd10), 8'(q_t % 12'd10)};
          umidade_media <= {8'(q_u / 12'd10), 8'(q_u % 12'd10)};
          estado <= PUBLICA;
        end
        default: estado <= OCIOSO;
      endcase
    end
endmodule
